// File: rtl/max7219_rx.sv
// MAX7219 serial responder: synchronises sclk/din/load into clki, assembles 16-bit
// frames and maintains the chip's register map with a one-cycle write strobe.
module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clki,
  input  logic        reset,
  input  logic        sclk,
  input  logic        din,
  input  logic        load,
  output logic        dout,
  output logic        wr,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_N-1:0] din_sync_q, din_sync_d;
  logic [SYNC_N-1:0] load_sync_q, load_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              load_prev_q, load_prev_d;
  logic [15:0]       shreg_q, shreg_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              wr_q, wr_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;
  logic [63:0]       digits_q, digits_d;
  logic [7:0]        decode_mode_q, decode_mode_d;
  logic [3:0]        intensity_q, intensity_d;
  logic [2:0]        scan_limit_q, scan_limit_d;
  logic              shutdown_n_q, shutdown_n_d;
  logic              display_test_q, display_test_d;

  logic sclk_s, din_s, load_s;
  logic sclk_rise, sclk_fall, load_rise;

  assign sclk_s    = sclk_sync_q[SYNC_N-1];
  assign din_s     = din_sync_q[SYNC_N-1];
  assign load_s    = load_sync_q[SYNC_N-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign load_rise = load_s & ~load_prev_q;

  always_comb begin
    sclk_sync_d    = {sclk_sync_q[SYNC_N-2:0], sclk};
    din_sync_d     = {din_sync_q[SYNC_N-2:0], din};
    load_sync_d    = {load_sync_q[SYNC_N-2:0], load};
    sclk_prev_d    = sclk_s;
    load_prev_d    = load_s;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    dout_d         = dout_q;
    wr_d           = 1'b0;
    frame_err_d    = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    digits_d       = digits_q;
    decode_mode_d  = decode_mode_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    shutdown_n_d   = shutdown_n_q;
    display_test_d = display_test_q;

    if (sclk_rise) begin
      shreg_d = {shreg_q[14:0], din_s};
      cnt_d   = (cnt_q == 5'd16) ? 5'd16 : cnt_q + 5'd1;
    end
    if (sclk_fall) begin
      dout_d = shreg_q[15];
    end

    // Commit sees the post-shift shreg/count so a coincident sclk rise is included.
    if (load_rise) begin
      if (cnt_d >= 5'd16) begin
        wr_d      = 1'b1;
        wr_addr_d = shreg_d[11:8];
        wr_data_d = shreg_d[7:0];
        case (shreg_d[11:8])
          4'h9:    decode_mode_d  = shreg_d[7:0];
          4'hA:    intensity_d    = shreg_d[3:0];
          4'hB:    scan_limit_d   = shreg_d[2:0];
          4'hC:    shutdown_n_d   = shreg_d[0];
          4'hF:    display_test_d = shreg_d[0];
          default: begin
            for (int n = 1; n <= 8; n++) begin
              if (shreg_d[11:8] == 4'(n)) digits_d[8*n-8 +: 8] = shreg_d[7:0];
            end
          end
        endcase
      end else begin
        frame_err_d = 1'b1;
      end
      cnt_d = 5'd0;
    end
  end

  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      sclk_sync_q    <= '0;
      din_sync_q     <= '0;
      load_sync_q    <= '0;
      sclk_prev_q    <= 1'b0;
      load_prev_q    <= 1'b0;
      shreg_q        <= '0;
      cnt_q          <= '0;
      dout_q         <= 1'b0;
      wr_q           <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_err_q    <= 1'b0;
      digits_q       <= '0;
      decode_mode_q  <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      shutdown_n_q   <= 1'b0;
      display_test_q <= 1'b0;
    end else begin
      sclk_sync_q    <= sclk_sync_d;
      din_sync_q     <= din_sync_d;
      load_sync_q    <= load_sync_d;
      sclk_prev_q    <= sclk_prev_d;
      load_prev_q    <= load_prev_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      dout_q         <= dout_d;
      wr_q           <= wr_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      frame_err_q    <= frame_err_d;
      digits_q       <= digits_d;
      decode_mode_q  <= decode_mode_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      shutdown_n_q   <= shutdown_n_d;
      display_test_q <= display_test_d;
    end
  end

  assign dout         = dout_q;
  assign wr           = wr_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_err    = frame_err_q;
  assign digits       = digits_q;
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign shutdown_n   = shutdown_n_q;
  assign display_test = display_test_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: serial frames driven from tasks, expected writes queued
// at each load rise and popped when the DUT strobes wr.
module tb_max7219_rx;
  logic        clki = 1'b0;
  logic        reset, sclk, din, load;
  logic        dout, wr, frame_err, shutdown_n, display_test;
  logic [3:0]  wr_addr, intensity;
  logic [7:0]  wr_data, decode_mode;
  logic [2:0]  scan_limit;
  logic [63:0] digits;

  max7219_rx #(.SYNC_STAGES(2)) dut (
    .clki(clki), .reset(reset), .sclk(sclk), .din(din), .load(load),
    .dout(dout), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .digits(digits), .decode_mode(decode_mode),
    .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
    .display_test(display_test)
  );

  always #5 clki = ~clki;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          err_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_pop;
  logic [15:0] m_sh;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every wr strobe must match the oldest queued frame.
  always @(negedge clki) begin
    if (reset) begin
      if (wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("wr_unexpected", wr, 1'b0);
        end else begin
          exp_pop = exp_q.pop_front();
          check_eq("wr_addr", wr_addr, exp_pop[11:8]);
          check_eq("wr_data", wr_data, exp_pop[7:0]);
        end
        check_eq("err_with_wr", frame_err, 1'b0);
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hlo, input int hhi, input bit chk_dout);
    din = b;
    tick(hlo);
    sclk = 1'b1;
    m_sh = {m_sh[14:0], b};
    if (m_cnt < 16) m_cnt++;
    tick(hhi);
    sclk = 1'b0;
    if (chk_dout) begin
      tick(5);
      check_eq("dout", dout, m_sh[15]);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, input int hlo,
                           input int hhi, input bit chk_dout);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], hlo, hhi, chk_dout);
  endtask

  task automatic commit();
    tick(2);
    load = 1'b1;
    if (m_cnt >= 16) exp_q.push_back(m_sh[11:0]);
    m_cnt = 0;
    tick(6);
    load = 1'b0;
    tick(6);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_digits"}, digits, 64'h0);
    check_eq({tag, "_misc"}, {decode_mode, intensity, scan_limit, shutdown_n, display_test,
                              dout, wr, wr_addr, wr_data, frame_err}, '0);
  endtask

  initial begin
    reset = 1'b0; sclk = 1'b0; din = 1'b0; load = 1'b0;
    m_sh = '0; m_cnt = 0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;
    tick(3);

    // 0x0A55 -> intensity
    send_word(32'h0A55, 16, 3, 4, 1'b1);
    commit();
    check_eq("t1_wr_cnt", wr_cnt, 1);
    check_eq("t1_intensity", intensity, 4'h5);
    check_eq("t1_wr_addr", wr_addr, 4'hA);
    check_eq("t1_wr_data", wr_data, 8'h55);
    check_eq("t1_digits", digits, 64'h0);
    check_eq("t1_other", {decode_mode, scan_limit, shutdown_n, display_test}, '0);
    check_eq("t1_err_cnt", err_cnt, 0);

    // digit 5 and shutdown release
    send_word(32'h05AA, 16, 3, 4, 1'b1);
    commit();
    send_word(32'h0C01, 16, 3, 4, 1'b1);
    commit();
    check_eq("t2_wr_cnt", wr_cnt, 3);
    check_eq("t2_digits", digits, 64'h0000_00AA_0000_0000);
    check_eq("t2_shutdown_n", shutdown_n, 1'b1);

    // short frame, then a full one proves the counter cleared
    send_word(32'h02FF, 10, 3, 4, 1'b1);
    commit();
    check_eq("t3_err_cnt", err_cnt, 1);
    check_eq("t3_wr_cnt", wr_cnt, 3);
    check_eq("t3_digits", digits, 64'h0000_00AA_0000_0000);
    send_word(32'h0301, 16, 3, 4, 1'b1);
    commit();
    check_eq("t3_wr_cnt2", wr_cnt, 4);
    check_eq("t3_digits2", digits, 64'h0000_00AA_0001_0000);

    // 32 bits, single load: only the last 16 count; dout checked per bit
    send_word(32'h0F01_0B07, 32, 3, 4, 1'b1);
    commit();
    check_eq("t4_wr_cnt", wr_cnt, 5);
    check_eq("t4_scan_limit", scan_limit, 3'h7);
    check_eq("t4_display_test", display_test, 1'b0);
    check_eq("t4_wr_addr", wr_addr, 4'hB);
    check_eq("t4_wr_data", wr_data, 8'h07);
    check_eq("t4_err_cnt", err_cnt, 1);

    // reset mid-frame
    send_word(32'h06, 8, 3, 4, 1'b1);
    tick(2);
    reset = 1'b0;
    m_sh = '0; m_cnt = 0;
    tick(1);
    check_all_zero("t5_reset");
    tick(2);
    reset = 1'b1;
    tick(3);
    check_eq("t5_wr_cnt", wr_cnt, 5);
    check_eq("t5_err_cnt", err_cnt, 1);
    send_word(32'h0612, 16, 3, 4, 1'b1);
    commit();
    check_eq("t5_wr_cnt2", wr_cnt, 6);
    check_eq("t5_digits", digits, 64'h0000_1200_0000_0000);

    // transmitter-paced frames (DIV=6: 3 clki per sclk level)
    send_word(32'h0A55, 16, 3, 3, 1'b0);
    commit();
    send_word(32'h05AA, 16, 3, 3, 1'b0);
    commit();
    check_eq("t6_intensity", intensity, 4'h5);
    check_eq("t6_digits", digits, 64'h0000_12AA_0000_0000);
    check_eq("t6_wr_cnt", wr_cnt, 8);
    check_eq("t6_err_cnt", err_cnt, 0 + 1);

    tick(4);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
